// File: rtl/font_text_arb.sv
// font_text_arb: round-robin arbiter for two writers into a character shadow buffer,
// with a sequential clear engine and a once-per-frame commit to the renderer-facing register.
module font_text_arb #(
  parameter int C_COLS    = 16,
  parameter int C_ROWS    = 12,
  parameter int C_CODE_W  = 5,
  parameter int C_VCOMMIT = 250
) (
  input  logic                                CK_i,
  input  logic                                XARST_i,
  input  logic                                PX_CK_EE_i,
  input  logic [8:0]                          VCTRs_i,
  input  logic                                A_REQ_i,
  input  logic [7:0]                          A_ADRs_i,
  input  logic [C_CODE_W-1:0]                 A_DATs_i,
  output logic                                A_ACK_o,
  input  logic                                B_REQ_i,
  input  logic [7:0]                          B_ADRs_i,
  input  logic [C_CODE_W-1:0]                 B_DATs_i,
  output logic                                B_ACK_o,
  input  logic                                CLR_REQ_i,
  output logic                                CLR_BUSY_o,
  output logic [C_COLS*C_ROWS*C_CODE_W-1:0]   DATss_o,
  output logic                                DIRTY_o,
  output logic                                COMMIT_o
);

  localparam int NCELL = C_COLS * C_ROWS;
  localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam logic [8:0]    ADR_LIM  = 9'(NCELL);
  localparam logic [IW-1:0] IDX_LAST = IW'(NCELL - 1);
  localparam logic [8:0]    VCOMMIT  = 9'(C_VCOMMIT);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  typedef struct packed {
    logic                en;
    logic [7:0]          addr;
    logic [C_CODE_W-1:0] dat;
  } wr_t;

  state_t                          state_q, state_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic                            rr_q, rr_d;       // 1: B has priority on a tie
  logic                            a_ack_q, a_ack_d;
  logic                            b_ack_q, b_ack_d;
  logic                            dirty_q, dirty_d;
  logic                            commit_q, commit_d;
  logic [8:0]                      vprev_q;
  logic [NCELL-1:0][C_CODE_W-1:0]  shadow_q, disp_q;
  wr_t                             wr;
  logic                            elig_a, elig_b, commit_ev;

  // Previous line is tracked on pixel enables only, so the event fires once per frame.
  assign commit_ev = PX_CK_EE_i && (VCTRs_i == VCOMMIT) && (vprev_q != VCOMMIT);
  assign elig_a    = A_REQ_i && !a_ack_q;
  assign elig_b    = B_REQ_i && !b_ack_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_d     = rr_q;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    dirty_d  = dirty_q;
    commit_d = 1'b0;
    wr       = '0;
    case (state_q)
      S_IDLE: begin
        if (commit_ev && dirty_q) begin
          commit_d = 1'b1;
          dirty_d  = 1'b0;
        end
        if (CLR_REQ_i) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end else if (elig_a && (!rr_q || !elig_b)) begin
          a_ack_d = 1'b1;
          rr_d    = 1'b1;
          wr.addr = A_ADRs_i;
          wr.dat  = A_DATs_i;
          wr.en   = ({1'b0, A_ADRs_i} < ADR_LIM);
        end else if (elig_b) begin
          b_ack_d = 1'b1;
          rr_d    = 1'b0;
          wr.addr = B_ADRs_i;
          wr.dat  = B_DATs_i;
          wr.en   = ({1'b0, B_ADRs_i} < ADR_LIM);
        end
        // A write landing with a commit keeps the buffer dirty for the next frame.
        if (wr.en) dirty_d = 1'b1;
      end
      S_CLEAR: begin
        wr.en   = 1'b1;
        wr.addr = 8'(idx_q);
        dirty_d = 1'b1;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      rr_q     <= 1'b0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      dirty_q  <= 1'b0;
      commit_q <= 1'b0;
      vprev_q  <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      dirty_q  <= dirty_d;
      commit_q <= commit_d;
      if (PX_CK_EE_i) vprev_q <= VCTRs_i;
      if (commit_d) disp_q <= shadow_q;
      for (int c = 0; c < NCELL; c++) begin
        if (wr.en && (wr.addr == 8'(c))) shadow_q[c] <= wr.dat;
      end
    end
  end

  assign A_ACK_o    = a_ack_q;
  assign B_ACK_o    = b_ack_q;
  assign CLR_BUSY_o = (state_q == S_CLEAR);
  assign DIRTY_o    = dirty_q;
  assign COMMIT_o   = commit_q;
  assign DATss_o    = disp_q;

endmodule

// File: tb/tb_font_text_arb.sv
// Bench for font_text_arb: directed scenarios plus random traffic, checked every cycle
// against a cell-array reference model of the shadow/commit behaviour.
module tb_font_text_arb;
  localparam int N  = 192;
  localparam int W  = 5;
  localparam int DW = N * W;
  localparam int VC = 250;

  logic          CK_i = 1'b0;
  logic          XARST_i;
  logic          PX_CK_EE_i = 1'b0;
  logic [8:0]    VCTRs_i = '0;
  logic          A_REQ_i = 1'b0, B_REQ_i = 1'b0, CLR_REQ_i = 1'b0;
  logic [7:0]    A_ADRs_i = '0, B_ADRs_i = '0;
  logic [W-1:0]  A_DATs_i = '0, B_DATs_i = '0;
  logic          A_ACK_o, B_ACK_o, CLR_BUSY_o, DIRTY_o, COMMIT_o;
  logic [DW-1:0] DATss_o;

  int total = 0;
  int bad   = 0;

  font_text_arb dut (
    .CK_i(CK_i), .XARST_i(XARST_i), .PX_CK_EE_i(PX_CK_EE_i), .VCTRs_i(VCTRs_i),
    .A_REQ_i(A_REQ_i), .A_ADRs_i(A_ADRs_i), .A_DATs_i(A_DATs_i), .A_ACK_o(A_ACK_o),
    .B_REQ_i(B_REQ_i), .B_ADRs_i(B_ADRs_i), .B_DATs_i(B_DATs_i), .B_ACK_o(B_ACK_o),
    .CLR_REQ_i(CLR_REQ_i), .CLR_BUSY_o(CLR_BUSY_o), .DATss_o(DATss_o),
    .DIRTY_o(DIRTY_o), .COMMIT_o(COMMIT_o)
  );

  always #5 CK_i = ~CK_i;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference model: what each output should read after the next edge.
  logic [W-1:0] sh[N];
  logic [W-1:0] dp[N];
  bit   m_acka, m_ackb, m_prefb, m_busy, m_dirty, m_commit;
  int   m_cidx;
  logic [8:0] m_pv;

  task automatic model_reset();
    for (int n = 0; n < N; n++) begin sh[n] = '0; dp[n] = '0; end
    m_acka = 0; m_ackb = 0; m_prefb = 0; m_busy = 0; m_dirty = 0; m_commit = 0;
    m_cidx = 0; m_pv = '0;
  endtask

  task automatic model_step();
    bit ev, ea, eb, ga, gb;
    ev = PX_CK_EE_i && (VCTRs_i == 9'(VC)) && (m_pv != 9'(VC));
    if (PX_CK_EE_i) m_pv = VCTRs_i;
    ga = 0; gb = 0; m_commit = 0;
    if (!m_busy) begin
      if (ev && m_dirty) begin
        for (int n = 0; n < N; n++) dp[n] = sh[n];
        m_dirty = 0; m_commit = 1;
      end
      if (CLR_REQ_i) begin
        m_busy = 1; m_cidx = 0;
      end else begin
        ea = A_REQ_i && !m_acka;
        eb = B_REQ_i && !m_ackb;
        if (ea && eb) begin ga = !m_prefb; gb = m_prefb; end
        else begin ga = ea; gb = eb; end
      end
    end else begin
      sh[m_cidx] = '0; m_dirty = 1;
      m_cidx++;
      if (m_cidx == N) m_busy = 0;
    end
    m_acka = ga; m_ackb = gb;
    if (ga) begin
      m_prefb = 1;
      if (int'(A_ADRs_i) < N) begin sh[A_ADRs_i] = A_DATs_i; m_dirty = 1; end
    end
    if (gb) begin
      m_prefb = 0;
      if (int'(B_ADRs_i) < N) begin sh[B_ADRs_i] = B_DATs_i; m_dirty = 1; end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    int fc;
    fc = 0;
    for (int n = N - 1; n >= 0; n--) if (obs[n*W +: W] !== exp[n*W +: W]) fc = n;
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cell=%0d got=%0h want=%0h", tag, fc, obs[fc*W +: W], exp[fc*W +: W]);
    end
  endtask

  function automatic logic [DW-1:0] pack_dp();
    logic [DW-1:0] r;
    for (int n = 0; n < N; n++) r[n*W +: W] = dp[n];
    return r;
  endfunction

  task automatic cyc();
    model_step();
    @(posedge CK_i); #1;
    chk("a_ack", A_ACK_o, m_acka);
    chk("b_ack", B_ACK_o, m_ackb);
    chk("busy", CLR_BUSY_o, m_busy);
    chk("dirty", DIRTY_o, m_dirty);
    chk("commit", COMMIT_o, m_commit);
    chk_vec("datss", DATss_o, pack_dp());
  endtask

  task automatic do_reset(input string tag);
    A_REQ_i = 0; B_REQ_i = 0; CLR_REQ_i = 0; PX_CK_EE_i = 0; VCTRs_i = '0;
    XARST_i = 0;
    #1;
    chk({tag, "_a_ack"}, A_ACK_o, 0);
    chk({tag, "_b_ack"}, B_ACK_o, 0);
    chk({tag, "_busy"}, CLR_BUSY_o, 0);
    chk({tag, "_dirty"}, DIRTY_o, 0);
    chk({tag, "_commit"}, COMMIT_o, 0);
    chk_vec({tag, "_datss"}, DATss_o, '0);
    model_reset();
    @(posedge CK_i); @(posedge CK_i); #1;
    XARST_i = 1;
  endtask

  task automatic frame_commit(output logic cm);
    PX_CK_EE_i = 1; VCTRs_i = 9'(VC - 1); cyc();
    VCTRs_i = 9'(VC); cyc(); cm = COMMIT_o;
    PX_CK_EE_i = 0; cyc();
  endtask

  initial begin
    logic          cm, pa, pb;
    int            bc;
    logic [DW-1:0] e;

    do_reset("rst");

    // Single write, visible only after the commit event.
    A_REQ_i = 1; A_ADRs_i = 8'd17; A_DATs_i = 5'h0A; cyc();
    chk("w17_ack", A_ACK_o, 1);
    chk("w17_dirty", DIRTY_o, 1);
    A_REQ_i = 0; cyc(); cyc();
    chk("w17_hold", DATss_o[85 +: 5], 0);
    frame_commit(cm);
    chk("w17_commit", cm, 1);
    chk("w17_cell", DATss_o[85 +: 5], 5'h0A);
    PX_CK_EE_i = 1; VCTRs_i = 9'(VC); cyc();
    chk("same_line_nocommit", COMMIT_o, 0);
    PX_CK_EE_i = 0; cyc();

    // Both requesters continuously: alternation, one grant per cycle.
    A_REQ_i = 1; B_REQ_i = 1; pa = 0; pb = 0;
    A_ADRs_i = 8'($urandom_range(0, N - 1)); A_DATs_i = 5'($urandom);
    B_ADRs_i = 8'($urandom_range(0, N - 1)); B_DATs_i = 5'($urandom);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("rr_one", 32'(A_ACK_o) + 32'(B_ACK_o), 1);
      chk("rr_a_consec", A_ACK_o & pa, 0);
      chk("rr_b_consec", B_ACK_o & pb, 0);
      pa = A_ACK_o; pb = B_ACK_o;
      if (A_ACK_o) begin A_ADRs_i = 8'($urandom_range(0, N - 1)); A_DATs_i = 5'($urandom); end
      if (B_ACK_o) begin B_ADRs_i = 8'($urandom_range(0, N - 1)); B_DATs_i = 5'($urandom); end
    end
    A_REQ_i = 0; B_REQ_i = 0; cyc();

    // Random traffic with frequent commit events and some out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      PX_CK_EE_i = ($urandom_range(0, 3) == 0);
      VCTRs_i = $urandom_range(0, 1) ? 9'(VC) : 9'(VC - 1);
      cyc();
      if (A_ACK_o || !A_REQ_i) begin
        A_REQ_i = 1'($urandom_range(0, 1));
        A_ADRs_i = 8'($urandom_range(0, 209)); A_DATs_i = 5'($urandom);
      end
      if (B_ACK_o || !B_REQ_i) begin
        B_REQ_i = 1'($urandom_range(0, 1));
        B_ADRs_i = 8'($urandom_range(0, 209)); B_DATs_i = 5'($urandom);
      end
    end
    A_REQ_i = 0; B_REQ_i = 0; PX_CK_EE_i = 0; cyc(); cyc();

    // Clear with a stalled A request and a commit event skipped mid-clear.
    CLR_REQ_i = 1; A_REQ_i = 1; A_ADRs_i = 8'd5; A_DATs_i = 5'h07; cyc();
    chk("clr_start_noack", A_ACK_o, 0);
    CLR_REQ_i = 0; A_REQ_i = 0;
    bc = CLR_BUSY_o ? 1 : 0;
    for (int i = 0; i < 300; i++) begin
      if (bc == 50) begin A_REQ_i = 1; A_ADRs_i = 8'd33; A_DATs_i = 5'h1F; end
      PX_CK_EE_i = (bc == 80 || bc == 81);
      VCTRs_i = (bc == 81) ? 9'(VC) : 9'(VC - 1);
      cyc();
      if (bc == 82) chk("clr_skip_commit", COMMIT_o, 0);
      if (!CLR_BUSY_o) break;
      bc++;
    end
    chk("clr_busy_len", bc, N);
    PX_CK_EE_i = 0;
    cyc();
    chk("clr_ack_after", A_ACK_o, 1);
    A_REQ_i = 0; cyc();
    frame_commit(cm);
    chk("clr_commit", cm, 1);
    e = '0; e[33*W +: W] = 5'h1F;
    chk_vec("clr_result", DATss_o, e);

    // Out-of-range write: acked, no dirty, no commit.
    A_REQ_i = 1; A_ADRs_i = 8'd200; A_DATs_i = 5'h03; cyc();
    chk("oor_ack", A_ACK_o, 1);
    chk("oor_dirty", DIRTY_o, 0);
    A_REQ_i = 0; cyc();
    frame_commit(cm);
    chk("oor_nocommit", cm, 0);

    // Write acked on the commit-event edge.
    A_REQ_i = 1; A_ADRs_i = 8'd5; A_DATs_i = 5'h11; cyc();
    A_REQ_i = 0; PX_CK_EE_i = 1; VCTRs_i = 9'(VC - 1); cyc();
    A_REQ_i = 1; A_DATs_i = 5'h12; VCTRs_i = 9'(VC); cyc();
    chk("wc_ack", A_ACK_o, 1);
    chk("wc_commit", COMMIT_o, 1);
    chk("wc_old", DATss_o[25 +: 5], 5'h11);
    chk("wc_dirty", DIRTY_o, 1);
    A_REQ_i = 0; PX_CK_EE_i = 0; cyc();
    frame_commit(cm);
    chk("wc_next_commit", cm, 1);
    chk("wc_new", DATss_o[25 +: 5], 5'h12);

    // Asynchronous reset at clear index 100 with a pending request.
    CLR_REQ_i = 1; cyc();
    CLR_REQ_i = 0; A_REQ_i = 1; A_ADRs_i = 8'd9; A_DATs_i = 5'h04;
    for (int i = 0; i < 100; i++) cyc();
    chk("mid_busy", CLR_BUSY_o, 1);
    do_reset("mid_rst");
    for (int i = 0; i < 3; i++) cyc();
    chk("post_rst_busy", CLR_BUSY_o, 0);
    chk("post_rst_ack", 32'(A_ACK_o) + 32'(B_ACK_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/font_text_arb.md
FONT_TEXT_ARB -- requirements
Module: font_text_arb

Interface
REQ-001 Parameter C_COLS, default 16: character columns per row.
REQ-002 Parameter C_ROWS, default 12: character rows.
REQ-003 Parameter C_CODE_W, default 5: character code width.
REQ-004 Parameter C_VCOMMIT, default 250: VCTRs_i line on which the shadow buffer is committed; inside vertical blanking.
REQ-005 CK_i  in  1  single system clock, rising edge; the only clock.
REQ-006 XARST_i  in  1  reset, asynchronous and active-low.
REQ-007 PX_CK_EE_i  in  1  pixel clock enable, one CK_i cycle wide.
REQ-008 VCTRs_i  in  9  video line counter from the video timing generator.
REQ-009 A_REQ_i / B_REQ_i  in  1  write request, requester A / B.
REQ-010 A_ADRs_i / B_ADRs_i  in  8  cell address = row*C_COLS+col.
REQ-011 A_DATs_i / B_DATs_i  in  C_CODE_W  character code to write.
REQ-012 A_ACK_o / B_ACK_o  out  1  one-cycle write acknowledge.
REQ-013 CLR_REQ_i  in  1  clear-all request, level or pulse.
REQ-014 CLR_BUSY_o  out  1  clear sequence in progress.
REQ-015 DATss_o  out  C_COLS*C_ROWS*C_CODE_W  committed display codes for the font renderer; cell n occupies bits [n*C_CODE_W +: C_CODE_W].
REQ-016 DIRTY_o  out  1  shadow buffer differs from the last commit.
REQ-017 COMMIT_o  out  1  one-cycle pulse when DATss_o is updated.

Function
REQ-018 Storage: the shadow array and the DATss_o register SHALL each hold C_COLS*C_ROWS cells (192 by default).
REQ-019 Control FSM states SHALL be IDLE and CLEAR.
REQ-020 Eligibility: in IDLE, a requester SHALL be eligible when its REQ is 1 and its ACK_o is currently 0.
REQ-021 Grant: one grant per cycle, round-robin, starting with A after reset; the pointer SHALL move to the other requester after each grant.
REQ-022 Write timing: a grant sampled at edge n SHALL write the shadow cell and assert that requester's ACK_o at edge n+1, for exactly one cycle.
REQ-023 Requester contract: hold REQ/ADR/DAT stable until ACK_o, then deassert REQ (or present a new request) on the following cycle.
REQ-024 Out-of-range address (>= C_COLS*C_ROWS): SHALL be acknowledged normally; shadow unchanged; DIRTY_o unchanged.
REQ-025 An in-range write SHALL set DIRTY_o at the same edge as ACK_o.
REQ-026 Clear start: CLR_REQ_i=1 in IDLE SHALL enter CLEAR at the next edge, with CLR_BUSY_o=1 and the cell index at 0.
REQ-027 Clear start priority: CLR_REQ_i wins over A/B requests on the same cycle.
REQ-028 CLEAR: one shadow cell SHALL be written with 0 per CK_i cycle, index 0..C_COLS*C_ROWS-1; no A/B grants; DIRTY_o set.
REQ-029 Clear end: after the last cell, return to IDLE; CLR_BUSY_o SHALL be high for exactly C_COLS*C_ROWS cycles (192).
REQ-030 CLR_REQ_i SHALL be ignored while in CLEAR; a level still high on return to IDLE SHALL start a new clear.
REQ-031 Commit event: the first cycle with PX_CK_EE_i=1, VCTRs_i==C_VCOMMIT, and a registered previous VCTRs_i value different from C_VCOMMIT.
REQ-032 Commit: on a commit event in IDLE with DIRTY_o=1, DATss_o <= shadow, DIRTY_o <= 0, and COMMIT_o pulses at the same edge.
REQ-033 No commit with DIRTY_o=0: a commit event SHALL do nothing and produce no COMMIT_o.
REQ-034 Commit during CLEAR: the commit SHALL be skipped; DIRTY_o stays 1 and the commit retries on the next frame.
REQ-035 Simultaneous write and commit: DATss_o SHALL take the pre-write shadow; the write lands in the shadow; DIRTY_o ends 1.
REQ-036 DATss_o SHALL change only at COMMIT_o edges.

Reset
REQ-037 XARST_i=0 SHALL asynchronously clear the shadow, DATss_o, ACKs, CLR_BUSY_o, DIRTY_o, COMMIT_o and the previous-line register; set FSM to IDLE and the round-robin pointer to A.
REQ-038 Mid-operation reset: reset during CLEAR or mid-handshake SHALL abort it; no pending ACK_o is issued after reset release.
REQ-039 Reset release: the first grant is possible on the first edge after XARST_i rises.

Verification
REQ-040 A writes addr 17 = 5'h0A -> A_ACK_o one cycle at n+1, DIRTY_o=1, DATss_o unchanged until the C_VCOMMIT event; then bits [85+:5]=0A and COMMIT_o for 1 cycle.
REQ-041 A and B request continuously from reset -> ACKs alternate A,B,A,B with a grant every cycle where eligible; no requester is acked on two consecutive cycles.
REQ-042 CLR_REQ_i pulse after filled shadow -> CLR_BUSY_o high exactly 192 cycles; A request during it stalls then is acked 1 cycle after busy drops; next commit shows all zeros except A's cell.
REQ-043 Write to addr 200 -> ACK issued, DIRTY_o stays 0, no COMMIT_o on next frame.
REQ-044 Write acked on the exact commit-event edge -> COMMIT_o pulses with the old value and DIRTY_o=1; the new value appears at the next frame's commit.
REQ-045 XARST_i low at clear index 100 -> all outputs 0; after release, IDLE with no residual ACK and CLR_BUSY_o=0.
